// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-stream-to-binary converter.
// Holds the converter FSM state type and the default window exponent.
package sc_pkg;

    // Default window exponent: a window holds 2^SC_DEFAULT_WIDTH valid samples.
    localparam int SC_DEFAULT_WIDTH = 8;

    // Converter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } sc_state_e;

endpackage : sc_pkg

// File: rtl/sc_counter.sv
// Up-counter with synchronous reset, synchronous clear and count enable.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (highest priority)
//   clear - synchronous clear to zero (beats enable)
//   en    - increment by one this cycle
//   count - current count value, W bits
module sc_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count register: reset, then clear, then increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule : sc_counter

// File: rtl/sc_stream_to_binary.sv
// Converts a unipolar stochastic bitstream into a binary count of ones over
// a window of exactly 2^WIDTH valid samples. The value represented is
// result / 2^WIDTH; any scaling for an adder-chain source is left to the
// consumer.
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous active-high reset, overrides everything
//   start        - begin a window (only honoured in IDLE)
//   clear        - synchronous abort to IDLE; counters zeroed, result kept
//   bit_in       - stochastic stream bit
//   bit_valid    - qualifies bit_in as a sample this cycle
//   result       - ones in the last completed window (WIDTH+1 bits)
//   result_valid - high while result is offered to the consumer
//   result_ready - consumer accepts result
//   busy         - high while a window is being counted
module sc_stream_to_binary
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    // Counters are one bit wider than WIDTH so a full window of 2^WIDTH
    // never wraps either of them.
    localparam int CW = WIDTH + 1;
    // Sample count seen just before the final sample of a window arrives.
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << WIDTH) - 1);

    sc_state_e       state_r;
    sc_state_e       state_s;
    logic [CW-1:0]   samples_s;
    logic [CW-1:0]   ones_s;
    logic [CW-1:0]   ones_final_s;
    logic            cnt_clear_s;
    logic            sample_en_s;
    logic            ones_en_s;
    logic            final_s;
    logic [WIDTH:0]  result_r;
    logic            result_valid_r;
    logic            busy_r;

    // Counters restart when a window opens and are zeroed by an abort.
    assign cnt_clear_s = clear || ((state_r == ST_IDLE) && start);
    assign sample_en_s = (state_r == ST_COUNT) && bit_valid;
    assign ones_en_s   = sample_en_s && bit_in;

    // The closing sample is folded into the result on the same edge that
    // enters DONE, so add it here rather than waiting for the counter.
    assign final_s      = sample_en_s && (samples_s == LAST_IDX) && !clear;
    assign ones_final_s = ones_s + CW'(bit_in);

    sc_counter #(.W(CW)) u_samples (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear_s),
        .en    (sample_en_s),
        .count (samples_s)
    );

    sc_counter #(.W(CW)) u_ones (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear_s),
        .en    (ones_en_s),
        .count (ones_s)
    );

    // Next-state logic; clear overrides start, sampling and handshake.
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_COUNT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (final_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_COUNT;
                    end
                end
                ST_DONE: begin
                    // result_valid is always high in DONE, so ready alone
                    // completes the handshake; start is ignored here.
                    if (result_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, result and output flags; flags are derived from the next state
    // so they line up with the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            result_r       <= final_s ? ones_final_s : result_r;
            result_valid_r <= (state_s == ST_DONE);
            busy_r         <= (state_s == ST_COUNT);
        end
    end

    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;

endmodule : sc_stream_to_binary
